// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state encoding and a clog2 helper for counter sizing.
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop line synchroniser plus last-tick register for start-edge detection.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic ser_in,
   output logic ser_in_s,
   output logic fall_edge
);
   logic meta, last;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         meta     <= 1'b1;
         ser_in_s <= 1'b1;
         last     <= 1'b1;
      end else begin
         meta     <= ser_in;
         ser_in_s <= meta;
         if (enable) last <= ser_in_s;
      end
   // comparing against the last-tick value keeps edges seen while enable is low
   assign fall_edge = last & ~ser_in_s;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with start-bit validation.
// Define UART_RX_PARITY_EN to add a parity bit after the data and check it against PAR_ODD.
module uart_rx_param import uart_pkg::*; #(
   parameter int DATA_BITS = 8,
   parameter int OVS       = 16,
   parameter int STOP_BITS = 1,
   parameter int PAR_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 ser_in,
   output logic [DATA_BITS-1:0] dout_byte,
   output logic                 dout_byte_rdy,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);
   localparam int CW = clog2(OVS);
`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   if (DATA_BITS < 5 || DATA_BITS > 9 || OVS < 8 || OVS > 64 || OVS % 2 != 0 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PAR_ODD < 0 || PAR_ODD > 1) begin : g_bad_param
      $error("uart_rx_param: illegal parameter set");
   end
   state_t               state;
   logic [CW-1:0]        sample_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 ferr_l;
   logic                 ser_in_s, fall_edge, mid, full;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
`endif
   uart_rx_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .ser_in   (ser_in),
      .ser_in_s (ser_in_s),
      .fall_edge(fall_edge)
   );
   assign mid  = sample_cnt == CW'(OVS/2 - 1);
   assign full = sample_cnt == CW'(OVS - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state         <= IDLE;
         sample_cnt    <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         ferr_l        <= 1'b0;
         dout_byte     <= '0;
         dout_byte_rdy <= 1'b0;
         frame_err     <= 1'b0;
         parity_err    <= 1'b0;
         busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit       <= 1'b0;
`endif
      end else begin
         dout_byte_rdy <= 1'b0;
         frame_err     <= 1'b0;
         parity_err    <= 1'b0;
         if (enable) begin
            sample_cnt <= full ? '0 : sample_cnt + 1'b1;
            case (state)
               IDLE: begin
                  sample_cnt <= '0;
                  bit_cnt    <= '0;
                  if (fall_edge) begin
                     state  <= START;
                     busy   <= 1'b1;
                     ferr_l <= 1'b0;
                  end
               end
               START: if (mid) begin
                  // line back high at mid-bit is a glitch, not a start bit
                  state      <= ser_in_s ? IDLE : DATA;
                  busy       <= ~ser_in_s;
                  sample_cnt <= '0;
               end
               DATA: if (full) begin
                  shreg   <= {ser_in_s, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt == 4'(DATA_BITS - 1) ? '0 : bit_cnt + 1'b1;
                  if (bit_cnt == 4'(DATA_BITS - 1)) state <= AFTER_DATA;
               end
`ifdef UART_RX_PARITY_EN
               PARITY: if (full) begin
                  par_bit <= ser_in_s;
                  state   <= STOP;
               end
`endif
               STOP: if (full) begin
                  if (!ser_in_s) ferr_l <= 1'b1;
                  bit_cnt <= bit_cnt + 1'b1;
                  // leave mid-stop-bit so a back-to-back start edge is not missed
                  if (bit_cnt == 4'(STOP_BITS - 1)) begin
                     state         <= IDLE;
                     busy          <= 1'b0;
                     bit_cnt       <= '0;
                     dout_byte     <= shreg;
                     dout_byte_rdy <= 1'b1;
                     frame_err     <= ferr_l | ~ser_in_s;
`ifdef UART_RX_PARITY_EN
                     parity_err    <= (^shreg ^ par_bit) != PAR_ODD[0];
`else
                     parity_err    <= 1'b0;
`endif
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames into an 8N1 receiver and a 7-bit, 2-stop variant.
module tb_uart_rx_param;
   localparam int PAR_ODD  = 0;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_EN   = 1;
`else
   localparam int PAR_EN   = 0;
`endif
   localparam int BIT_CLKS = 64;
   localparam int FRAME    = (10 + PAR_EN) * BIT_CLKS;
   localparam int LAT      = (8 + 16 * (9 + PAR_EN)) * 4;
   typedef struct {
      int b;
      int fe;
      int pe;
      int bz;
      int t;
   } rx_t;
   logic       clk = 1'b0;
   logic       rst, enable, ser_in, ser_in2, sel;
   logic [7:0] dout_byte;
   logic       rdy, ferr, perr, busy;
   logic [6:0] dout2;
   logic       rdy2, ferr2, perr2, busy2;
   int         checks = 0, errors = 0, cyc = 0, start_cyc = 0;
   bit         busy_seen = 0;
   rx_t        q1[$], q2[$];
   uart_rx_param #(.DATA_BITS(8), .OVS(16), .STOP_BITS(1), .PAR_ODD(PAR_ODD)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ser_in(ser_in),
      .dout_byte(dout_byte), .dout_byte_rdy(rdy), .frame_err(ferr),
      .parity_err(perr), .busy(busy)
   );
   uart_rx_param #(.DATA_BITS(7), .OVS(16), .STOP_BITS(2), .PAR_ODD(PAR_ODD)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .ser_in(ser_in2),
      .dout_byte(dout2), .dout_byte_rdy(rdy2), .frame_err(ferr2),
      .parity_err(perr2), .busy(busy2)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (busy) busy_seen = 1;
      if (rdy) q1.push_back('{int'(dout_byte), int'(ferr), int'(perr), int'(busy), cyc});
      if (rdy2) q2.push_back('{int'(dout2), int'(ferr2), int'(perr2), int'(busy2), cyc});
   end
   initial begin
      int k;
      k = 0;
      enable = 1'b0;
      forever begin
         @(negedge clk);
         k++;
         enable = (k % 4 == 0);
      end
   end
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic drive_bit(input logic b);
      if (sel) ser_in2 = b;
      else ser_in = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask
   task automatic idle_bits(input int n);
      ser_in  = 1'b1;
      ser_in2 = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask
   task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] stops,
                             input int ns, input logic pflip);
      logic p;
      p = (PAR_ODD != 0);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < nb; i++) begin
         drive_bit(d[i]);
         p ^= d[i];
      end
      if (PAR_EN != 0) drive_bit(p ^ pflip);
      for (int i = 0; i < ns; i++) drive_bit(stops[i]);
   endtask
   task automatic expect_rx(input string tag, input int which, input int b, input int fe,
                            input int pe);
      rx_t e;
      int  n;
      n = which != 0 ? q2.size() : q1.size();
      check({tag, "_count"}, n, 1);
      if (n > 0) begin
         if (which != 0) e = q2.pop_front();
         else e = q1.pop_front();
         check({tag, "_byte"}, e.b, b);
         check({tag, "_frame_err"}, e.fe, fe);
         check({tag, "_parity_err"}, e.pe, pe);
         check({tag, "_busy_at_rdy"}, e.bz, 0);
      end
      q1.delete();
      q2.delete();
   endtask
   initial begin
      logic [7:0] b2b[3];
      logic [7:0] d;
      b2b = '{8'h00, 8'hFF, 8'h81};
      rst = 1'b1;
      ser_in = 1'b1;
      ser_in2 = 1'b1;
      sel = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_byte", dout_byte, 0);
      check("rst_rdy", rdy, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", ferr, 0);
      check("rst_parity_err", perr, 0);
      check("rst_byte2", dout2, 0);
      rst = 1'b0;
      idle_bits(2);
      // 1: plain frame, latency and single-cycle pulse
      send_frame(9'h0A5, 8, 2'b11, 1, 1'b0);
      if (q1.size() > 0)
         check("t1_latency_window",
               int'(q1[0].t - start_cyc >= LAT + 3 && q1[0].t - start_cyc <= LAT + 6), 1);
      idle_bits(1);
      expect_rx("t1", 0, 'hA5, 0, 0);
      // 2: short low glitch rejected at mid start bit
      busy_seen = 0;
      ser_in = 1'b0;
      repeat (16) @(negedge clk);
      ser_in = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("t2_busy_pulse", int'(busy_seen), 1);
      check("t2_no_rdy", q1.size(), 0);
      check("t2_busy_idle", busy, 0);
      // 3: low stop bit flags frame error, next good frame is clean
      send_frame(9'h03C, 8, 2'b00, 1, 1'b0);
      idle_bits(2);
      expect_rx("t3_bad_stop", 0, 'h3C, 1, 0);
      send_frame(9'h055, 8, 2'b11, 1, 1'b0);
      idle_bits(1);
      expect_rx("t3_good", 0, 'h55, 0, 0);
      // 4: back-to-back frames, no idle gap
      for (int i = 0; i < 3; i++) send_frame({1'b0, b2b[i]}, 8, 2'b11, 1, 1'b0);
      idle_bits(1);
      check("t4_count", q1.size(), 3);
      if (q1.size() == 3) begin
         for (int i = 0; i < 3; i++) check("t4_byte", q1[i].b, int'(b2b[i]));
         check("t4_gap01", q1[1].t - q1[0].t, FRAME);
         check("t4_gap12", q1[2].t - q1[1].t, FRAME);
      end
      q1.delete();
`ifdef UART_RX_PARITY_EN
      // 5: even parity, good then corrupted parity bit
      send_frame(9'h007, 8, 2'b11, 1, 1'b0);
      idle_bits(1);
      expect_rx("t5_par_ok", 0, 'h07, 0, 0);
      send_frame(9'h007, 8, 2'b11, 1, 1'b1);
      idle_bits(1);
      expect_rx("t5_par_bad", 0, 'h07, 0, 1);
`endif
      // 6: reset mid-data aborts the frame
      d = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      repeat (BIT_CLKS / 2) @(negedge clk);
      check("t6_busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      check("t6_rst_byte", dout_byte, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_rdy", rdy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_bits(2);
      check("t6_no_rdy_aborted", q1.size(), 0);
      send_frame({1'b0, d}, 8, 2'b11, 1, 1'b0);
      idle_bits(1);
      expect_rx("t6_clean", 0, 'h5A, 0, 0);
      // variant: 7 data bits, 2 stop bits
      sel = 1'b1;
      send_frame(9'h05A, 7, 2'b11, 2, 1'b0);
      idle_bits(1);
      expect_rx("v_good", 1, 'h5A, 0, 0);
      send_frame(9'h02B, 7, 2'b01, 2, 1'b0);
      idle_bits(2);
      expect_rx("v_second_stop_low", 1, 'h2B, 1, 0);
      send_frame(9'h041, 7, 2'b11, 2, 1'b0);
      idle_bits(1);
      check("v_dut1_quiet", q1.size(), 0);
      expect_rx("v_after_err", 1, 'h41, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
